// File: rtl/video_wb_arbiter.sv
// -----------------------------------------------------------------------------
// video_wb_arbiter
//
// Two-master Wishbone arbiter in front of the shared frame RAM port.
//   m0 : video-in store engine (frame writes)
//   m1 : video-out fetch engine (frame reads)
// Round-robin on contention. Ownership is held for the whole CYC and for as
// long as the owner holds LOCK. A watchdog aborts a strobe that gets no ACK/ERR
// within TIMEOUT_CYC cycles, returns ERR to the owner and frees the bus.
//
// Ports
//   clk, nRST                      clock, synchronous active-low reset
//   m{0,1}_wb_*_I                  master request side (CYC/STB/LOCK/WE/SEL/ADR/DAT)
//   m{0,1}_wb_DAT_O/ACK_O/ERR_O    master response side (ACK/ERR to owner only)
//   s_wb_*_O                       slave request side (owner's signals, else 0)
//   s_wb_DAT_I/ACK_I/ERR_I         slave response side
//   grant                          one-hot current owner (00 = none)
//   timeout_flag                   sticky watchdog-expiry indicator
// -----------------------------------------------------------------------------
module video_wb_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              nRST,
    // master 0
    input  logic              m0_wb_CYC_I,
    input  logic              m0_wb_STB_I,
    input  logic              m0_wb_LOCK_I,
    input  logic              m0_wb_WE_I,
    input  logic [3:0]        m0_wb_SEL_I,
    input  logic [ADDR_W-1:0] m0_wb_ADR_I,
    input  logic [DATA_W-1:0] m0_wb_DAT_I,
    output logic [DATA_W-1:0] m0_wb_DAT_O,
    output logic              m0_wb_ACK_O,
    output logic              m0_wb_ERR_O,
    // master 1
    input  logic              m1_wb_CYC_I,
    input  logic              m1_wb_STB_I,
    input  logic              m1_wb_LOCK_I,
    input  logic              m1_wb_WE_I,
    input  logic [3:0]        m1_wb_SEL_I,
    input  logic [ADDR_W-1:0] m1_wb_ADR_I,
    input  logic [DATA_W-1:0] m1_wb_DAT_I,
    output logic [DATA_W-1:0] m1_wb_DAT_O,
    output logic              m1_wb_ACK_O,
    output logic              m1_wb_ERR_O,
    // slave
    output logic              s_wb_CYC_O,
    output logic              s_wb_STB_O,
    output logic              s_wb_LOCK_O,
    output logic              s_wb_WE_O,
    output logic [3:0]        s_wb_SEL_O,
    output logic [ADDR_W-1:0] s_wb_ADR_O,
    output logic [DATA_W-1:0] s_wb_DAT_O,
    input  logic [DATA_W-1:0] s_wb_DAT_I,
    input  logic              s_wb_ACK_I,
    input  logic              s_wb_ERR_I,
    // status
    output logic [1:0]        grant,
    output logic              timeout_flag
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

    state_t     state_q, state_d;
    logic       last_owner_q, last_owner_d;
    logic       abort_owner_q, abort_owner_d;
    logic [7:0] wdog_q, wdog_d;
    logic       timeout_flag_q, timeout_flag_d;

    // Master inputs packed into index-able form so the owner mux is one line.
    logic [1:0]        cyc_in, stb_in, lock_in, we_in;
    logic [3:0]        sel_in [2];
    logic [ADDR_W-1:0] adr_in [2];
    logic [DATA_W-1:0] dat_in [2];

    assign cyc_in    = {m1_wb_CYC_I,  m0_wb_CYC_I};
    assign stb_in    = {m1_wb_STB_I,  m0_wb_STB_I};
    assign lock_in   = {m1_wb_LOCK_I, m0_wb_LOCK_I};
    assign we_in     = {m1_wb_WE_I,   m0_wb_WE_I};
    assign sel_in[0] = m0_wb_SEL_I;
    assign sel_in[1] = m1_wb_SEL_I;
    assign adr_in[0] = m0_wb_ADR_I;
    assign adr_in[1] = m1_wb_ADR_I;
    assign dat_in[0] = m0_wb_DAT_I;
    assign dat_in[1] = m1_wb_DAT_I;

    logic owner_valid;
    logic owner_idx;

    assign owner_valid = (state_q == ST_OWN0) || (state_q == ST_OWN1);
    assign owner_idx   = (state_q == ST_OWN1);

    // Slave side: plain mux of the owner's signals; nothing driven in IDLE/ABORT.
    always_comb begin
        s_wb_CYC_O  = 1'b0;
        s_wb_STB_O  = 1'b0;
        s_wb_LOCK_O = 1'b0;
        s_wb_WE_O   = 1'b0;
        s_wb_SEL_O  = '0;
        s_wb_ADR_O  = '0;
        s_wb_DAT_O  = '0;
        if (owner_valid) begin
            s_wb_CYC_O  = cyc_in[owner_idx];
            s_wb_STB_O  = stb_in[owner_idx];
            s_wb_LOCK_O = lock_in[owner_idx];
            s_wb_WE_O   = we_in[owner_idx];
            s_wb_SEL_O  = sel_in[owner_idx];
            s_wb_ADR_O  = adr_in[owner_idx];
            s_wb_DAT_O  = dat_in[owner_idx];
        end
    end

    // Master responses: gated by the forwarded STB so a late slave ACK after
    // the owner dropped its strobe (or while IDLE) never reaches a master.
    logic [1:0] ack_out, err_out;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            logic is_owner;
            assign is_owner     = owner_valid && (owner_idx == 1'(gi));
            assign ack_out[gi]  = s_wb_ACK_I && s_wb_STB_O && is_owner;
            assign err_out[gi]  = (s_wb_ERR_I && s_wb_STB_O && is_owner) ||
                                  ((state_q == ST_ABORT) && (abort_owner_q == 1'(gi)));
        end
    endgenerate

    assign m0_wb_ACK_O = ack_out[0];
    assign m1_wb_ACK_O = ack_out[1];
    assign m0_wb_ERR_O = err_out[0];
    assign m1_wb_ERR_O = err_out[1];
    assign m0_wb_DAT_O = s_wb_DAT_I;
    assign m1_wb_DAT_O = s_wb_DAT_I;

    // grant keeps showing the aborted owner during its ERR cycle.
    always_comb begin
        case (state_q)
            ST_OWN0:  grant = 2'b01;
            ST_OWN1:  grant = 2'b10;
            ST_ABORT: grant = abort_owner_q ? 2'b10 : 2'b01;
            default:  grant = 2'b00;
        endcase
    end

    assign timeout_flag = timeout_flag_q;

    always_comb begin
        state_d        = state_q;
        last_owner_d   = last_owner_q;
        abort_owner_d  = abort_owner_q;
        wdog_d         = wdog_q;
        timeout_flag_d = timeout_flag_q;

        case (state_q)
            ST_IDLE: begin
                wdog_d = 8'd0;
                // On a tie, the master that did not own the bus last wins.
                if (cyc_in[0] && (!cyc_in[1] || last_owner_q)) begin
                    state_d = ST_OWN0;
                end else if (cyc_in[1]) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!cyc_in[owner_idx] && !lock_in[owner_idx]) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner_idx;
                    wdog_d       = 8'd0;
                end else if (s_wb_STB_O && !s_wb_ACK_I && !s_wb_ERR_I) begin
                    // Stalled strobe; an ACK in the limit cycle takes this
                    // branch's else and so wins over the timeout.
                    if (wdog_q + 8'd1 == TIMEOUT_LIM) begin
                        state_d        = ST_ABORT;
                        abort_owner_d  = owner_idx;
                        timeout_flag_d = 1'b1;
                        wdog_d         = 8'd0;
                    end else begin
                        wdog_d = wdog_q + 8'd1;
                    end
                end else begin
                    wdog_d = 8'd0;
                end
            end
            default: begin // ST_ABORT
                state_d      = ST_IDLE;
                last_owner_d = abort_owner_q;
                wdog_d       = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q        <= ST_IDLE;
            last_owner_q   <= 1'b1;
            abort_owner_q  <= 1'b0;
            wdog_q         <= 8'd0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_owner_q   <= last_owner_d;
            abort_owner_q  <= abort_owner_d;
            wdog_q         <= wdog_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

endmodule

// File: tb/tb_video_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_video_wb_arbiter
//
// Drives both masters and plays the RAM slave by hand. Every transfer that is
// expected to complete with ACK is pushed to a scoreboard queue when issued;
// a monitor pops it when the slave ACK reaches the bus and checks address,
// direction, data and which master got the ACK. Scenario tasks check grant,
// LOCK, watchdog, ERR and reset behaviour inline.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_video_wb_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              nrst;
    logic              m0_cyc, m0_stb, m0_lock, m0_we;
    logic [3:0]        m0_sel;
    logic [ADDR_W-1:0] m0_adr;
    logic [DATA_W-1:0] m0_dat_w, m0_dat_r;
    logic              m0_ack, m0_err;
    logic              m1_cyc, m1_stb, m1_lock, m1_we;
    logic [3:0]        m1_sel;
    logic [ADDR_W-1:0] m1_adr;
    logic [DATA_W-1:0] m1_dat_w, m1_dat_r;
    logic              m1_ack, m1_err;
    logic              s_cyc, s_stb, s_lock, s_we;
    logic [3:0]        s_sel;
    logic [ADDR_W-1:0] s_adr;
    logic [DATA_W-1:0] s_dat_o, s_dat_i;
    logic              s_ack, s_err;
    logic [1:0]        grant;
    logic              timeout_flag;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic              who;
        logic              we;
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] dat;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    video_wb_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .nRST(nrst),
        .m0_wb_CYC_I(m0_cyc), .m0_wb_STB_I(m0_stb), .m0_wb_LOCK_I(m0_lock),
        .m0_wb_WE_I(m0_we), .m0_wb_SEL_I(m0_sel), .m0_wb_ADR_I(m0_adr),
        .m0_wb_DAT_I(m0_dat_w), .m0_wb_DAT_O(m0_dat_r),
        .m0_wb_ACK_O(m0_ack), .m0_wb_ERR_O(m0_err),
        .m1_wb_CYC_I(m1_cyc), .m1_wb_STB_I(m1_stb), .m1_wb_LOCK_I(m1_lock),
        .m1_wb_WE_I(m1_we), .m1_wb_SEL_I(m1_sel), .m1_wb_ADR_I(m1_adr),
        .m1_wb_DAT_I(m1_dat_w), .m1_wb_DAT_O(m1_dat_r),
        .m1_wb_ACK_O(m1_ack), .m1_wb_ERR_O(m1_err),
        .s_wb_CYC_O(s_cyc), .s_wb_STB_O(s_stb), .s_wb_LOCK_O(s_lock),
        .s_wb_WE_O(s_we), .s_wb_SEL_O(s_sel), .s_wb_ADR_O(s_adr),
        .s_wb_DAT_O(s_dat_o), .s_wb_DAT_I(s_dat_i),
        .s_wb_ACK_I(s_ack), .s_wb_ERR_I(s_err),
        .grant(grant), .timeout_flag(timeout_flag)
    );

    // Scoreboard monitor: one line per completed transfer.
    always @(negedge clk) begin
        if (nrst && s_stb && s_ack) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_ack got adr=%h want no transfer", s_adr);
            end else begin
                mon_e = sb_q.pop_front();
                if ({s_we, s_adr} !== {mon_e.we, mon_e.adr}) begin
                    n_fail++;
                    $display("FAIL sb_adr_we got we=%b adr=%h want we=%b adr=%h",
                             s_we, s_adr, mon_e.we, mon_e.adr);
                end
                n_checks++;
                if (mon_e.we && (s_dat_o !== mon_e.dat)) begin
                    n_fail++;
                    $display("FAIL sb_wdata got %h want %h", s_dat_o, mon_e.dat);
                end else if (!mon_e.we && ((mon_e.who ? m1_dat_r : m0_dat_r) !== mon_e.dat)) begin
                    n_fail++;
                    $display("FAIL sb_rdata got %h want %h",
                             mon_e.who ? m1_dat_r : m0_dat_r, mon_e.dat);
                end
                n_checks++;
                if ({m1_ack, m0_ack} !== (mon_e.who ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL sb_ack_owner got %b want %b",
                             {m1_ack, m0_ack}, mon_e.who ? 2'b10 : 2'b01);
                end
                $display("txn m%0d we=%b adr=%h dat=%h", mon_e.who, mon_e.we, mon_e.adr, mon_e.dat);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_cyc = 0; m0_stb = 0; m0_lock = 0; m0_we = 0; m0_sel = 0; m0_adr = 0; m0_dat_w = 0;
        m1_cyc = 0; m1_stb = 0; m1_lock = 0; m1_we = 0; m1_sel = 0; m1_adr = 0; m1_dat_w = 0;
        s_dat_i = 0; s_ack = 0; s_err = 0;
    endtask

    task automatic apply_reset();
        nrst = 1'b0;
        clear_inputs();
        repeat (2) step();
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++;
        if (grant !== 2'b00) begin n_fail++; $display("FAIL rst_grant got %b want 00", grant); end
        n_checks++;
        if (timeout_flag !== 1'b0) begin n_fail++; $display("FAIL rst_tflag got %b want 0", timeout_flag); end
        n_checks++;
        if ({s_cyc, s_stb, s_lock, s_we} !== 4'b0) begin
            n_fail++; $display("FAIL rst_sbus got %b want 0000", {s_cyc, s_stb, s_lock, s_we});
        end
        n_checks++;
        if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0) begin
            n_fail++; $display("FAIL rst_resp got %b want 0000", {m0_ack, m0_err, m1_ack, m1_err});
        end
        $display("test_reset done");
    endtask

    task automatic test_single_write();
        step();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF; m0_adr = 32'h1000; m0_dat_w = 32'hCAFE;
        sb_q.push_back('{who: 1'b0, we: 1'b1, adr: 32'h1000, dat: 32'hCAFE});
        #1;
        n_checks++;
        if ({grant, s_cyc} !== 3'b000) begin n_fail++; $display("FAIL t1_latency got %b want 000", {grant, s_cyc}); end
        step();
        n_checks++;
        if (grant !== 2'b01) begin n_fail++; $display("FAIL t1_grant got %b want 01", grant); end
        n_checks++;
        if ({s_cyc, s_stb, s_we, s_sel, s_adr} !== {3'b111, 4'hF, 32'h1000}) begin
            n_fail++; $display("FAIL t1_mirror got cyc=%b stb=%b we=%b sel=%h adr=%h want 1 1 1 f 00001000",
                               s_cyc, s_stb, s_we, s_sel, s_adr);
        end
        n_checks++;
        if (m0_ack !== 1'b0) begin n_fail++; $display("FAIL t1_early_ack got %b want 0", m0_ack); end
        step();
        s_ack = 1; // monitor checks address/data/ack owner this cycle
        #1;
        n_checks++;
        if (m1_ack !== 1'b0) begin n_fail++; $display("FAIL t1_m1_ack got %b want 0", m1_ack); end
        step();
        s_ack = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
        #1;
        n_checks++;
        if (m0_ack !== 1'b0) begin n_fail++; $display("FAIL t1_ack_len got %b want 0", m0_ack); end
        step();
        n_checks++;
        if (grant !== 2'b00) begin n_fail++; $display("FAIL t1_release got %b want 00", grant); end
        $display("test_single_write done");
    endtask

    task automatic test_contention();
        apply_reset();
        m0_cyc = 1; m1_cyc = 1;
        step();
        n_checks++;
        if (grant !== 2'b01) begin n_fail++; $display("FAIL t2_first_tie got %b want 01", grant); end
        m0_cyc = 0;
        step();
        n_checks++;
        if ({grant, s_cyc} !== 3'b000) begin n_fail++; $display("FAIL t2_turnaround got %b want 000", {grant, s_cyc}); end
        step();
        n_checks++;
        if (grant !== 2'b10) begin n_fail++; $display("FAIL t2_own1 got %b want 10", grant); end
        m1_stb = 1; m1_we = 0; m1_sel = 4'hF; m1_adr = 32'h2004; s_dat_i = 32'h1234_5678; s_ack = 1;
        sb_q.push_back('{who: 1'b1, we: 1'b0, adr: 32'h2004, dat: 32'h1234_5678});
        step();
        s_ack = 0; m1_stb = 0; m1_cyc = 0; m0_cyc = 1;
        step();
        n_checks++;
        if (grant !== 2'b00) begin n_fail++; $display("FAIL t2_idle2 got %b want 00", grant); end
        m1_cyc = 1;
        step();
        n_checks++;
        if (grant !== 2'b10 && grant !== 2'b01) begin
            n_fail++; $display("FAIL t2_alt got %b want 01", grant);
        end else if (grant !== 2'b01) begin
            n_fail++; $display("FAIL t2_alt got %b want 01", grant);
        end
        clear_inputs();
        $display("test_contention done");
    endtask

    task automatic test_lock();
        logic [2:0] pat;
        pat = 3'b101;
        apply_reset();
        m1_cyc = 1; m1_lock = 1;
        step();
        n_checks++;
        if ({grant, s_lock} !== 3'b101) begin n_fail++; $display("FAIL t3_lock_grant got %b want 101", {grant, s_lock}); end
        m0_cyc = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            m1_cyc = pat[k];
            #1;
            n_checks++;
            if ({grant, s_lock, s_cyc} !== {2'b10, 1'b1, pat[k]}) begin
                n_fail++; $display("FAIL t3_hold[%0d] got %b want %b", k, {grant, s_lock, s_cyc}, {2'b10, 1'b1, pat[k]});
            end
        end
        step();
        m1_cyc = 0; m1_lock = 0;
        #1;
        n_checks++;
        if (s_lock !== 1'b0) begin n_fail++; $display("FAIL t3_unlock got %b want 0", s_lock); end
        step();
        n_checks++;
        if (grant !== 2'b00) begin n_fail++; $display("FAIL t3_idle got %b want 00", grant); end
        step();
        n_checks++;
        if (grant !== 2'b01) begin n_fail++; $display("FAIL t3_m0_next got %b want 01", grant); end
        clear_inputs();
        $display("test_lock done");
    endtask

    task automatic test_timeout();
        apply_reset();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF; m0_adr = 32'h4000; m0_dat_w = 32'h0BAD;
        m1_cyc = 1;
        step();
        n_checks++;
        if (grant !== 2'b01) begin n_fail++; $display("FAIL t4_grant got %b want 01", grant); end
        for (int k = 2; k <= 8; k++) begin
            step();
            n_checks++;
            if ({m0_err, s_cyc} !== 2'b01) begin
                n_fail++; $display("FAIL t4_stall[%0d] got err,cyc=%b want 01", k, {m0_err, s_cyc});
            end
        end
        step();
        n_checks++;
        if ({m0_err, m1_err, s_cyc, s_stb} !== 4'b1000) begin
            n_fail++; $display("FAIL t4_abort got %b want 1000", {m0_err, m1_err, s_cyc, s_stb});
        end
        n_checks++;
        if (timeout_flag !== 1'b1) begin n_fail++; $display("FAIL t4_tflag got %b want 1", timeout_flag); end
        m0_cyc = 0; m0_stb = 0; m0_we = 0;
        step();
        n_checks++;
        if ({m0_err, grant, timeout_flag} !== 4'b0001) begin
            n_fail++; $display("FAIL t4_after got %b want 0001", {m0_err, grant, timeout_flag});
        end
        step();
        n_checks++;
        if (grant !== 2'b10) begin n_fail++; $display("FAIL t4_m1_granted got %b want 10", grant); end
        $display("test_timeout done");
    endtask

    task automatic test_slave_err();
        // continues with m1 owning the bus
        m1_stb = 1; m1_we = 0; m1_adr = 32'h5000; s_err = 1;
        #1;
        n_checks++;
        if ({m1_err, m0_err} !== 2'b10) begin n_fail++; $display("FAIL t5_err got %b want 10", {m1_err, m0_err}); end
        step();
        s_err = 0; m1_stb = 0;
        #1;
        n_checks++;
        if ({m1_err, grant} !== 3'b010) begin n_fail++; $display("FAIL t5_no_abort got %b want 010", {m1_err, grant}); end
        m1_cyc = 0;
        step();
        n_checks++;
        if ({grant, timeout_flag} !== 3'b001) begin
            n_fail++; $display("FAIL t5_release got %b want 001", {grant, timeout_flag});
        end
        $display("test_slave_err done");
    endtask

    task automatic test_reset_mid_burst();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF; m0_adr = 32'h6000; m0_dat_w = 32'h55AA;
        sb_q.push_back('{who: 1'b0, we: 1'b1, adr: 32'h6000, dat: 32'h55AA});
        step();
        n_checks++;
        if (grant !== 2'b01) begin n_fail++; $display("FAIL t6_grant got %b want 01", grant); end
        s_ack = 1;
        step();
        nrst = 0; m0_adr = 32'h6004;
        step();
        n_checks++;
        if ({grant, s_cyc, s_stb, m0_ack, m0_err} !== 6'b0) begin
            n_fail++; $display("FAIL t6_reset_out got %b want 000000", {grant, s_cyc, s_stb, m0_ack, m0_err});
        end
        n_checks++;
        if (timeout_flag !== 1'b0) begin n_fail++; $display("FAIL t6_tflag got %b want 0", timeout_flag); end
        nrst = 1; s_ack = 0; m0_stb = 0; m1_cyc = 1;
        step();
        n_checks++;
        if (grant !== 2'b01) begin n_fail++; $display("FAIL t6_tie_after_rst got %b want 01", grant); end
        clear_inputs();
        $display("test_reset_mid_burst done");
    endtask

    initial begin
        nrst = 1'b0;
        clear_inputs();
        test_reset();
        test_single_write();
        test_contention();
        test_lock();
        test_timeout();
        test_slave_err();
        test_reset_mid_burst();
        step();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover got %0d want 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
